// File: rtl/dvp_pattern_gen.sv
// dvp_pattern_gen: synthetic OV5640-style DVP source producing RGB565 test frames
// Ports: sys_clk pixel clock; sys_rst async active-high reset; pix_ce pixel-rate enable;
//        enable run request (sampled at frame boundaries); pattern_sel / solid_rgb pattern
//        controls (latched at frame start); cmos_vsync / cmos_href / cmos_data DVP outputs;
//        frame_done one-cycle end-of-frame pulse; busy high outside IDLE.
module dvp_pattern_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_BLANK   = 160,
    parameter int V_ACTIVE  = 480,
    parameter int VSYNC_LEN = 4,
    parameter int V_BACK    = 16,
    parameter int V_FRONT   = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        pix_ce,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_rgb,
    output logic        cmos_vsync,
    output logic        cmos_href,
    output logic [15:0] cmos_data,
    output logic        frame_done,
    output logic        busy
);
    localparam int          H_TOTAL  = H_ACTIVE + H_BLANK;
    localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0] BAR_LAST = 16'(H_ACTIVE / 8 - 1);
    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;
    // each stage hands over to the next non-empty stage; IDLE marks the end of the frame
    localparam state_t AFTER_ACT  = (V_FRONT != 0) ? VFRONT : IDLE;
    localparam state_t AFTER_BACK = (V_ACTIVE != 0) ? ACTIVE : AFTER_ACT;
    localparam state_t AFTER_SYNC = (V_BACK != 0) ? VBACK : AFTER_BACK;
    localparam state_t FIRST      = (VSYNC_LEN != 0) ? VSYNC : AFTER_SYNC;
    function automatic logic [15:0] len_of(state_t s);
        return s == VSYNC ? 16'(VSYNC_LEN) : s == VBACK ? 16'(V_BACK) :
               s == ACTIVE ? 16'(V_ACTIVE) : s == VFRONT ? 16'(V_FRONT) : 16'd0;
    endfunction
    function automatic state_t succ_of(state_t s);
        return s == VSYNC ? AFTER_SYNC : s == VBACK ? AFTER_BACK : s == ACTIVE ? AFTER_ACT : IDLE;
    endfunction
    state_t      state, state_n;
    logic [15:0] h, h_n, line, line_n, bar_pos, bar_pos_n, solid, solid_n, pix, data_n;
    logic [2:0]  bar_idx, bar_idx_n;
    logic [1:0]  pat, pat_n;
    logic        line_end, state_end, frame_end, start, vsync_n, href_n, done_n;
    // outputs are registered from the next-cycle counter values so href and data line up with the state
    always_comb begin
        line_end  = h == H_LAST;
        state_end = state != IDLE && line_end && line == len_of(state) - 16'd1;
        frame_end = state_end && succ_of(state) == IDLE;
        start     = enable && (state == IDLE || frame_end);
        state_n   = start ? FIRST : (state == IDLE || frame_end) ? IDLE : state_end ? succ_of(state) : state;
        h_n       = (state == IDLE || line_end) ? 16'd0 : h + 16'd1;
        line_n    = (state == IDLE || state_end) ? 16'd0 : line_end ? line + 16'd1 : line;
        bar_pos_n = (h_n == 16'd0 || bar_pos == BAR_LAST) ? 16'd0 : bar_pos + 16'd1;
        bar_idx_n = h_n == 16'd0 ? 3'd0 : bar_pos == BAR_LAST ? bar_idx + 3'd1 : bar_idx;
        pat_n     = start ? pattern_sel : pat;
        solid_n   = start ? solid_rgb : solid;
        vsync_n   = state_n == VSYNC;
        href_n    = state_n == ACTIVE && h_n < 16'(H_ACTIVE);
        done_n    = state_n != IDLE && h_n == H_LAST && line_n == len_of(state_n) - 16'd1 &&
                    succ_of(state_n) == IDLE;
        pix       = pat_n == 2'd0 ? BARS[bar_idx_n] :
                    pat_n == 2'd1 ? {h_n[4:0], h_n[5:0], h_n[4:0]} :
                    pat_n == 2'd2 ? solid_n : (h_n[3] ^ line_n[3]) ? 16'hFFFF : 16'h0000;
        data_n    = href_n ? pix : 16'h0000;
    end
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            h          <= '0;
            line       <= '0;
            bar_pos    <= '0;
            bar_idx    <= '0;
            pat        <= '0;
            solid      <= '0;
            cmos_vsync <= 1'b0;
            cmos_href  <= 1'b0;
            cmos_data  <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else if (pix_ce) begin
            state      <= state_n;
            h          <= h_n;
            line       <= line_n;
            bar_pos    <= bar_pos_n;
            bar_idx    <= bar_idx_n;
            pat        <= pat_n;
            solid      <= solid_n;
            cmos_vsync <= vsync_n;
            cmos_href  <= href_n;
            cmos_data  <= data_n;
            frame_done <= done_n;
            busy       <= state_n != IDLE;
        end else begin
            frame_done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dvp_pattern_gen.sv
// tb_dvp_pattern_gen: directed self-checking bench for dvp_pattern_gen
module tb_dvp_pattern_gen;
    logic        clk = 1'b0, rst = 1'b1, pix_ce = 1'b1, enable = 1'b0, en1 = 1'b0, en2 = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [15:0] solid_rgb = 16'h0000;
    logic        vs0, hr0, fd0, bz0, vs1, hr1, fd1, bz1, vs2, hr2, fd2, bz2;
    logic [15:0] d0, d1, d2;
    int          vectors = 0, miscompares = 0;
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    int          rx [5] = '{0, 1, 31, 32, 63};
    logic [15:0] rv [5] = '{16'h0000, 16'h0821, 16'hFBFF, 16'h0400, 16'hFFFF};

    always #5 clk = ~clk;

    dvp_pattern_gen #(.H_ACTIVE(8), .H_BLANK(4), .V_ACTIVE(4), .VSYNC_LEN(2), .V_BACK(1), .V_FRONT(1)) u0 (
        .sys_clk(clk), .sys_rst(rst), .pix_ce(pix_ce), .enable(enable), .pattern_sel(pattern_sel),
        .solid_rgb(solid_rgb), .cmos_vsync(vs0), .cmos_href(hr0), .cmos_data(d0), .frame_done(fd0), .busy(bz0));
    dvp_pattern_gen #(.H_ACTIVE(64), .H_BLANK(4), .V_ACTIVE(4), .VSYNC_LEN(2), .V_BACK(1), .V_FRONT(1)) u1 (
        .sys_clk(clk), .sys_rst(rst), .pix_ce(1'b1), .enable(en1), .pattern_sel(2'd1),
        .solid_rgb(16'h0000), .cmos_vsync(vs1), .cmos_href(hr1), .cmos_data(d1), .frame_done(fd1), .busy(bz1));
    dvp_pattern_gen #(.H_ACTIVE(16), .H_BLANK(4), .V_ACTIVE(16), .VSYNC_LEN(2), .V_BACK(1), .V_FRONT(1)) u2 (
        .sys_clk(clk), .sys_rst(rst), .pix_ce(1'b1), .enable(en2), .pattern_sel(2'd3),
        .solid_rgb(16'h0000), .cmos_vsync(vs2), .cmos_href(hr2), .cmos_data(d2), .frame_done(fd2), .busy(bz2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_vs(output int n);
        n = 0;
        while (vs0 !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (vs0 !== 1'b1) check("vsync start timeout", 32'd0, 32'd1);
    endtask

    // Called on the first negedge with vsync high; per cycle t the frame position is c = t/scale
    // (12-cycle lines: 2 vsync, 1 back porch, 4 active, 1 front porch). Returns on the next frame's t=0.
    task automatic run_frame(input string tag, input int scale, input int mode, input int drop_t);
        int c, hh, ln;
        logic hr;
        logic [15:0] dd;
        for (int t = 0; t < 96 * scale; t++) begin
            c  = t / scale;
            hh = c % 12;
            ln = c / 12;
            hr = ln >= 3 && ln < 7 && hh < 8;
            dd = !hr ? 16'h0000 : mode == 2 ? 16'h1234 : bars[hh];
            check($sformatf("%s t=%0d {done,busy,vsync,href,data}", tag, t), {fd0, bz0, vs0, hr0, d0},
                  {(c == 95 && t % scale == 0), 1'b1, (ln < 2), hr, dd});
            if (t == drop_t) begin
                enable      = 1'b0;
                pattern_sel = 2'd2;
                solid_rgb   = 16'h1234;
            end
            pix_ce = (scale == 1) || (t % 2 == 1);
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("reset vsync", vs0, 0);
        check("reset href", hr0, 0);
        check("reset data", d0, 0);
        check("reset frame_done", fd0, 0);
        check("reset busy", bz0, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle busy", bz0, 0);
        enable = 1'b1;
        @(negedge clk);
        wait_vs(n);
        check("enable to vsync latency", n, 0);
        run_frame("bars f0", 1, 0, -1);
        check("back-to-back vsync", vs0, 1);
        run_frame("bars f1", 1, 0, 50);
        repeat (4) begin
            check("idle gap busy", bz0, 0);
            check("idle gap vsync", vs0, 0);
            @(negedge clk);
        end
        enable = 1'b1;
        @(negedge clk);
        wait_vs(n);
        run_frame("solid", 1, 2, 10);
        check("idle after solid", bz0, 0);
        pattern_sel = 2'd0;
        enable = 1'b1;
        @(negedge clk);
        wait_vs(n);
        run_frame("ce toggle", 2, 0, 10);
        check("idle after toggle", bz0, 0);
        pattern_sel = 2'd0;
        enable = 1'b1;
        @(negedge clk);
        wait_vs(n);
        n = 0;
        while (hr0 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("href reached", hr0, 1);
        repeat (3) @(negedge clk);
        check("mid-line href", hr0, 1);
        check("mid-line data", d0, 16'h07E0);
        rst = 1'b1;
        #1;
        check("async reset href", hr0, 0);
        check("async reset data", d0, 0);
        check("async reset vsync", vs0, 0);
        check("async reset busy", bz0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wait_vs(n);
        check("vsync after reset latency", n, 0);
        run_frame("after reset", 1, 0, 10);
        en1 = 1'b1;
        en2 = 1'b1;
        @(negedge clk);
        check("ramp vsync start", vs1, 1);
        check("checker vsync start", vs2, 1);
        for (int t = 0; t < 240; t++) begin
            for (int i = 0; i < 5; i++)
                if (t == 204 + rx[i]) check($sformatf("ramp x=%0d", rx[i]), {hr1, d1}, {1'b1, rv[i]});
            if (t == 203 || t == 268) check($sformatf("ramp blank t=%0d", t), {hr1, d1}, 17'd0);
            if (t >= 60 && t < 76)
                check($sformatf("checker y=0 x=%0d", t - 60), {hr2, d2}, {1'b1, (t - 60 >= 8) ? 16'hFFFF : 16'h0000});
            if (t >= 220 && t < 236)
                check($sformatf("checker y=8 x=%0d", t - 220), {hr2, d2}, {1'b1, (t - 220 < 8) ? 16'hFFFF : 16'h0000});
            if (t == 76) check("checker blank", {hr2, d2}, 17'd0);
            @(negedge clk);
        end
        en1 = 1'b0;
        en2 = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
